// File: rtl/spicebox_pkg.sv
// rtl/spicebox_pkg.sv - shared capture-path types and default sizes
package spicebox_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_DEPTH  = 512;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POST,
    READOUT
  } cap_state_t;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port sample RAM, synchronous read, no reset
module capture_ram #(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 512,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_buffer.sv
// rtl/capture_buffer.sv - pre/post-trigger circular capture with oldest-first readout
module capture_buffer
  import spicebox_pkg::*;
#(
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int PRE_SAMPLES = DEFAULT_DEPTH / 2,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              trigger,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              rd_last,
  output logic              busy,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam logic [ADDR_W:0]   PRE_CNT   = (ADDR_W+1)'(PRE_SAMPLES);
  localparam logic [ADDR_W:0]   POST_CNT  = (ADDR_W+1)'(DEPTH - PRE_SAMPLES);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);

  cap_state_t        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   cnt_inc;
  logic [ADDR_W:0]   rd_issued;
  logic              q_valid;
  logic              q_last;
  logic [DATA_W-1:0] ram_q;
  logic              skid_valid;
  logic              skid_last;
  logic [DATA_W-1:0] skid_data;
  logic              ram_we;
  logic              issue;
  logic              out_take;
  logic              out_next;
  logic              skid_next;
  logic              rd_fire;

  // A read is issued only if the word it returns next cycle is guaranteed a slot
  // in the output/skid pair, whatever rd_ready does then.
  always_comb begin
    ram_we    = sample_valid && (state == PRETRIG || state == ARMED || state == POST);
    out_take  = !rd_valid || rd_ready;
    out_next  = out_take ? (skid_valid || q_valid) : 1'b1;
    skid_next = out_take ? (skid_valid && q_valid) : (skid_valid || q_valid);
    issue     = (state == READOUT) && (rd_issued != DEPTH_CNT) && !(out_next && skid_next);
    rd_fire   = rd_valid && rd_ready;
    cnt_inc   = cnt + CNT_ONE;
  end

  assign busy = (state != IDLE);

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (sample_data),
    .re    (issue),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      rd_issued  <= '0;
      q_valid    <= 1'b0;
      q_last     <= 1'b0;
      skid_valid <= 1'b0;
      skid_last  <= 1'b0;
      skid_data  <= '0;
      rd_valid   <= 1'b0;
      rd_last    <= 1'b0;
      rd_data    <= '0;
      trig_addr  <= '0;
    end else begin
      q_valid <= issue;
      q_last  <= issue && (rd_issued == DEPTH_CNT - CNT_ONE);
      if (issue) begin
        rd_ptr    <= rd_ptr + PTR_ONE;
        rd_issued <= rd_issued + CNT_ONE;
      end

      case (state)
        IDLE: begin
          if (arm) begin
            wr_ptr <= '0;
            cnt    <= '0;
            state  <= PRETRIG;
          end
        end

        PRETRIG: begin
          if (sample_valid) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            cnt    <= cnt_inc;
            if (cnt_inc == PRE_CNT) state <= ARMED;
          end
        end

        ARMED: begin
          if (sample_valid) wr_ptr <= wr_ptr + PTR_ONE;
          if (trigger) begin
            trig_addr <= wr_ptr;
            cnt       <= {{ADDR_W{1'b0}}, sample_valid};
            if (sample_valid && POST_CNT == CNT_ONE) begin
              state     <= READOUT;
              rd_ptr    <= wr_ptr + PTR_ONE;
              rd_issued <= '0;
            end else begin
              state <= POST;
            end
          end
        end

        POST: begin
          if (sample_valid) begin
            wr_ptr <= wr_ptr + PTR_ONE;
            cnt    <= cnt_inc;
            // The pointer past the final post write lands on the oldest pre-trigger sample.
            if (cnt_inc == POST_CNT) begin
              state     <= READOUT;
              rd_ptr    <= wr_ptr + PTR_ONE;
              rd_issued <= '0;
            end
          end
        end

        READOUT: begin
          if (out_take) begin
            if (skid_valid) begin
              rd_data  <= skid_data;
              rd_last  <= skid_last;
              rd_valid <= 1'b1;
              if (q_valid) begin
                skid_data <= ram_q;
                skid_last <= q_last;
              end else begin
                skid_valid <= 1'b0;
              end
            end else if (q_valid) begin
              rd_data  <= ram_q;
              rd_last  <= q_last;
              rd_valid <= 1'b1;
            end else begin
              rd_valid <= 1'b0;
              rd_last  <= 1'b0;
            end
          end else if (q_valid) begin
            skid_valid <= 1'b1;
            skid_data  <= ram_q;
            skid_last  <= q_last;
          end

          if (rd_fire && rd_last) begin
            state      <= IDLE;
            rd_valid   <= 1'b0;
            rd_last    <= 1'b0;
            skid_valid <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_buffer.sv
// tb/tb_capture_buffer.sv - directed self-checking bench for capture_buffer
module tb_capture_buffer;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int PRE    = 4;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              arm = 1'b0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              trigger = 1'b0;
  logic              rd_ready = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
  logic              busy;
  logic [ADDR_W-1:0] trig_addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  capture_buffer #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .PRE_SAMPLES (PRE)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .trigger      (trigger),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .rd_last      (rd_last),
    .busy         (busy),
    .trig_addr    (trig_addr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_arm();
    @(negedge clk);
    sample_valid = 1'b0;
    trigger      = 1'b0;
    arm          = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  // Valid samples first..first+count-1, each preceded by gap idle cycles; a
  // sample matching t_a/t_b/t_c carries trigger, or the idle cycle before it does.
  task automatic feed(input int first, input int count, input int gap,
                      input int t_a, input int t_b, input int t_c, input bit trig_on_idle);
    int v;
    bit hit;
    for (int i = 0; i < count; i++) begin
      v   = first + i;
      hit = (v == t_a) || (v == t_b) || (v == t_c);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        sample_valid = 1'b0;
        trigger      = trig_on_idle && hit && (g == gap - 1);
      end
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = DATA_W'(v);
      trigger      = hit && !trig_on_idle;
    end
  endtask

  task automatic read_window(input int first, input bit bp, input bit lat);
    int got = 0;
    int cyc = 0;
    int first_cyc = -1;
    int unstable = 0;
    logic held = 1'b0;
    logic [DATA_W-1:0] held_data = '0;
    while (got < DEPTH && cyc < 500) begin
      @(negedge clk);
      cyc++;
      sample_valid = 1'b0;
      trigger      = 1'b0;
      if (rd_valid === 1'b1 && first_cyc < 0) first_cyc = cyc;
      if (held && !(rd_valid === 1'b1 && rd_data === held_data)) unstable++;
      rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rd_valid === 1'b1 && rd_ready) begin
        check("rd_data", 32'(rd_data), 32'(first + got));
        check("rd_last", 32'(rd_last), 32'(got == DEPTH - 1));
        got++;
      end
      held      = (rd_valid === 1'b1) && !rd_ready;
      held_data = rd_data;
    end
    check("transfers", 32'(got), 32'(DEPTH));
    check("hold_stable", 32'(unstable), 32'd0);
    if (lat) check("first_valid_latency", 32'(first_cyc > 0 && first_cyc <= 3), 32'd1);
    @(negedge clk);
    check("rd_valid_after_last", 32'(rd_valid), 32'd0);
    check("busy_after_last", 32'(busy), 32'd0);
    rd_ready = 1'b0;
  endtask

  initial begin
    int bad;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_trig_addr", 32'(trig_addr), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    rst_n = 1'b1;

    // Basic: trigger with sample 20 -> window 16..31, trigger at address 4
    do_arm();
    check("basic_busy", 32'(busy), 32'd1);
    feed(0, 32, 0, 20, -1, -1, 1'b0);
    check("basic_trig_addr", 32'(trig_addr), 32'd4);
    read_window(16, 1'b0, 1'b1);
    check("basic_trig_addr_hold", 32'(trig_addr), 32'd4);

    // Early triggers on 1 and 3 ignored; trigger on 10 -> window 6..21
    do_arm();
    feed(0, 22, 0, 1, 3, 10, 1'b0);
    check("early_trig_addr", 32'(trig_addr), 32'd10);
    read_window(6, 1'b0, 1'b1);

    // Backpressure: trigger on 120 (address 4) -> window 116..131
    do_arm();
    feed(100, 32, 0, 120, -1, -1, 1'b0);
    check("bp_trig_addr", 32'(trig_addr), 32'd4);
    read_window(116, 1'b1, 1'b0);

    // Gappy input, trigger on an idle cycle before sample 20 -> window 16..31
    do_arm();
    feed(0, 32, 2, 20, -1, -1, 1'b1);
    check("gap_trig_addr", 32'(trig_addr), 32'd4);
    read_window(16, 1'b0, 1'b1);

    // Long ARMED phase: trigger on 104 (address 8) -> window 100..115
    do_arm();
    feed(0, 116, 0, 104, -1, -1, 1'b0);
    check("wrap_trig_addr", 32'(trig_addr), 32'd8);
    read_window(100, 1'b0, 1'b1);

    // Reset in the middle of POST
    do_arm();
    feed(0, 25, 0, 20, -1, -1, 1'b0);
    check("mid_post_busy", 32'(busy), 32'd1);
    @(negedge clk);
    sample_valid = 1'b0;
    trigger      = 1'b0;
    rst_n        = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_trig_addr", 32'(trig_addr), 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    rd_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rd_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("no_output_after_reset", 32'(bad), 32'd0);
    rd_ready = 1'b0;

    // arm while ARMED is ignored; fresh capture: trigger on 14 -> window 10..25
    do_arm();
    feed(0, 10, 0, -1, -1, -1, 1'b0);
    @(negedge clk);
    sample_valid = 1'b0;
    arm          = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check("rearm_busy", 32'(busy), 32'd1);
    feed(10, 16, 0, 14, -1, -1, 1'b0);
    check("rearm_trig_addr", 32'(trig_addr), 32'd14);
    read_window(10, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
